// File: rtl/prio_pkt_fifo_pkg.sv
// Shared types and helpers for the multi-queue priority packet FIFO.
package prio_pkt_fifo_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    // Framing flags stored with every beat; payload width is set per instance.
    typedef struct packed {
        logic sop;
        logic eop;
    } beat_tag_t;

    // Queue pointers carry one extra MSB to tell full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/prio_pkt_fifo_queue.sv
// One circular beat queue with packet counting; optional framing check
// and partial-packet rollback under `PRIO_PKT_FIFO_PROTO_CHK_EN.
module prio_pkt_queue
    import prio_pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              wr_sop,
    input  logic              wr_eop,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic              full,
    output logic              empty,
    output logic              has_pkt,
    output logic              head_sop,
    output logic              head_eop,
    output logic [DATA_W-1:0] head_data
`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
    ,
    output logic              proto_err
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned IDX_W = PTR_W - 1;

    typedef struct packed {
        beat_tag_t         tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             accept;
    logic             wr_eop_acc;
    logic             rd_eop;

    assign full      = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign has_pkt   = (pkt_cnt_q != '0);
    assign head      = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign head_sop  = head.tag.sop;
    assign head_eop  = head.tag.eop;
    assign head_data = head.data;

    assign wr_entry.tag.sop = wr_sop;
    assign wr_entry.tag.eop = wr_eop;
    assign wr_entry.data    = wr_data;

`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
    logic             in_pkt_q, in_pkt_d;
    logic [PTR_W-1:0] start_ptr_q, start_ptr_d;
    logic             illegal;

    // Legal framing alternates: sop only outside a packet, never inside one.
    assign illegal   = wr_req && (wr_sop == in_pkt_q);
    assign accept    = wr_req && !illegal;
    assign proto_err = illegal;
`else
    assign accept = wr_req;
`endif

    assign wr_eop_acc = accept && wr_eop;
    assign rd_eop     = rd_en && head.tag.eop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_eop_acc && !rd_eop) begin
            pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
        end else if (!wr_eop_acc && rd_eop) begin
            pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
        end
`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
        in_pkt_d    = in_pkt_q;
        start_ptr_d = start_ptr_q;
        if (accept) begin
            in_pkt_d = !wr_eop;
            if (wr_sop) begin
                start_ptr_d = wr_ptr_q;
            end
        end else if (illegal && wr_sop) begin
            // Abandon the open packet: its beats were never counted or readable.
            in_pkt_d = 1'b0;
            wr_ptr_d = start_ptr_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
            in_pkt_q    <= 1'b0;
            start_ptr_q <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
            in_pkt_q    <= in_pkt_d;
            start_ptr_q <= start_ptr_d;
`endif
        end
    end

endmodule

// File: rtl/prio_pkt_fifo.sv
// Strict-priority, packet-atomic multi-queue FIFO; optional err output
// under `PRIO_PKT_FIFO_PROTO_CHK_EN.
module prio_pkt_fifo
    import prio_pkt_fifo_pkg::*;
#(
    parameter  int unsigned DATA_W   = 256,
    parameter  int unsigned NUM_PRIO = 8,
    parameter  int unsigned DEPTH    = 16,
    localparam int unsigned PRIO_W   = $clog2(NUM_PRIO)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_vld,
    input  logic                wr_sop,
    input  logic                wr_eop,
    input  logic [PRIO_W-1:0]   wr_prio,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_ready,
    input  logic                read,
    output logic                sop,
    output logic                eop,
    output logic                vld,
    output logic [DATA_W-1:0]   out_data,
    output logic [PRIO_W-1:0]   out_prio,
    output logic [NUM_PRIO-1:0] q_empty,
    output logic [NUM_PRIO-1:0] q_full
`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
    ,
    output logic                err
`endif
);

    logic [NUM_PRIO-1:0] wr_req;
    logic [NUM_PRIO-1:0] rd_en;
    logic [NUM_PRIO-1:0] has_pkt;
    logic [NUM_PRIO-1:0] head_sop;
    logic [NUM_PRIO-1:0] head_eop;
    logic [DATA_W-1:0]   head_data [NUM_PRIO];

    arb_state_e          state_q, state_d;
    logic [PRIO_W-1:0]   sel_q, sel_d;
    logic [PRIO_W-1:0]   pick;
    logic [PRIO_W-1:0]   pop_idx;
    logic                pop;

    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                vld_q, vld_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [PRIO_W-1:0]   out_prio_q, out_prio_d;

    assign wr_ready = !q_full[wr_prio];

`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
    logic [NUM_PRIO-1:0] proto_err;
    logic                err_q, err_d;
`endif

    for (genvar p = 0; p < NUM_PRIO; p++) begin : g_queue
        assign wr_req[p] = wr_vld && wr_ready && (wr_prio == PRIO_W'(p));
        assign rd_en[p]  = pop && (pop_idx == PRIO_W'(p));

        prio_pkt_queue #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_queue (
            .clk       (clk),
            .rst       (rst),
            .wr_req    (wr_req[p]),
            .wr_sop    (wr_sop),
            .wr_eop    (wr_eop),
            .wr_data   (wr_data),
            .rd_en     (rd_en[p]),
            .full      (q_full[p]),
            .empty     (q_empty[p]),
            .has_pkt   (has_pkt[p]),
            .head_sop  (head_sop[p]),
            .head_eop  (head_eop[p]),
            .head_data (head_data[p])
`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
            ,
            .proto_err (proto_err[p])
`endif
        );
    end

    // Lowest-index queue holding at least one complete packet.
    always_comb begin
        pick = '0;
        for (int unsigned i = NUM_PRIO; i > 0; i--) begin
            if (has_pkt[i-1]) begin
                pick = PRIO_W'(i - 1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        pop        = 1'b0;
        pop_idx    = sel_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        out_data_d = out_data_q;
        out_prio_d = out_prio_q;

        unique case (state_q)
            IDLE: begin
                if (read && (has_pkt != '0)) begin
                    pop     = 1'b1;
                    pop_idx = pick;
                    sel_d   = pick;
                    if (!head_eop[pick]) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                // The locked packet is complete, so its queue never runs dry here.
                if (read) begin
                    pop = 1'b1;
                    if (head_eop[sel_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        vld_d = pop;
        if (pop) begin
            sop_d      = head_sop[pop_idx];
            eop_d      = head_eop[pop_idx];
            out_data_d = head_data[pop_idx];
            out_prio_d = pop_idx;
        end
    end

`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
    assign err_d = |proto_err;
    assign err   = err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            vld_q      <= 1'b0;
            out_data_q <= '0;
            out_prio_q <= '0;
`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            vld_q      <= vld_d;
            out_data_q <= out_data_d;
            out_prio_q <= out_prio_d;
`ifdef PRIO_PKT_FIFO_PROTO_CHK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign sop      = sop_q;
    assign eop      = eop_q;
    assign vld      = vld_q;
    assign out_data = out_data_q;
    assign out_prio = out_prio_q;

endmodule
